read_pointer_handler_param: RTL and testbench

Parametrised read-side pointer manager for the async FIFO family, living entirely in the rx clock domain. It keeps the binary read counter and produces the RAM read address. It publishes a registered Gray-coded read pointer for CDC to the write side, and derives empty status from the already-synchronised Gray write pointer. Beyond the 8-deep generation, it adds generic depth, occupancy level, an almost-empty threshold, a pop acknowledge, a sticky underflow flag and a read-side flush.

---
 rtl/read_pointer_handler_param.sv | 98 +++++++++
 tb/tb_read_pointer_handler_param.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/read_pointer_handler_param.sv
// read_pointer_handler_param
//   Read-side pointer manager for the async FIFO family. Everything runs in
//   the clk_rx domain. It keeps the binary read counter, drives the RAM read
//   address, publishes a registered Gray read pointer toward the write side,
//   and derives empty / level / almost_empty from the synchronised Gray
//   write pointer. It also provides pop acknowledge, a sticky underflow flag
//   and a read-side flush.
//
// Parameters
//   ADDR_W     address width; depth = 2**ADDR_W; pointers are ADDR_W+1 bits
//   AEMPTY_TH  almost_empty asserts when level <= AEMPTY_TH (0..2**ADDR_W)
//
// Ports
//   clk_rx                          in   rx-domain clock
//   nrst_rx                         in   synchronous active-low reset
//   pop                             in   read request
//   flush                           in   drop all visible entries
//   clr_err                         in   clear underflow
//   synced_graycoded_write_pointer  in   Gray write pointer, already in clk_rx
//   pop_ack                         out  pop accepted this cycle
//   empty                           out  no entries visible
//   almost_empty                    out  level <= AEMPTY_TH
//   level                           out  visible entries, 0..2**ADDR_W
//   underflow                       out  sticky: pop seen while empty
//   read_pointer                    out  RAM read address
//   graycoded_read_pointer          out  registered Gray read pointer (CDC)
module read_pointer_handler_param #(
  parameter int ADDR_W    = 3,
  parameter int AEMPTY_TH = 2
) (
  input  logic              clk_rx,
  input  logic              nrst_rx,
  input  logic              pop,
  input  logic              flush,
  input  logic              clr_err,
  input  logic [ADDR_W:0]   synced_graycoded_write_pointer,
  output logic              pop_ack,
  output logic              empty,
  output logic              almost_empty,
  output logic [ADDR_W:0]   level,
  output logic              underflow,
  output logic [ADDR_W-1:0] read_pointer,
  output logic [ADDR_W:0]   graycoded_read_pointer
);

  localparam logic [ADDR_W:0] AEMPTY_TH_W = (ADDR_W+1)'(AEMPTY_TH);
  localparam logic [ADDR_W:0] PTR_ONE     = (ADDR_W+1)'(1);

  function automatic logic [ADDR_W:0] bin2gray(input logic [ADDR_W:0] b);
    return b ^ (b >> 1);
  endfunction

  // Prefix XOR from the MSB down.
  function automatic logic [ADDR_W:0] gray2bin(input logic [ADDR_W:0] g);
    logic [ADDR_W:0] b;
    b[ADDR_W] = g[ADDR_W];
    for (int i = ADDR_W - 1; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  logic [ADDR_W:0] read_counter;
  logic [ADDR_W:0] read_gray;
  logic [ADDR_W:0] write_bin;

  assign read_gray    = bin2gray(read_counter);
  assign write_bin    = gray2bin(synced_graycoded_write_pointer);

  // Empty is a straight Gray compare, so it does not wait on the decoder.
  assign empty        = (read_gray == synced_graycoded_write_pointer);
  assign level        = write_bin - read_counter;
  assign almost_empty = (level <= AEMPTY_TH_W);
  assign pop_ack      = pop & ~empty & ~flush;
  assign read_pointer = read_counter[ADDR_W-1:0];

  // Counter / CDC register stage: flush beats pop; Gray output lags by one.
  always_ff @(posedge clk_rx) begin
    if (!nrst_rx) begin
      read_counter           <= '0;
      graycoded_read_pointer <= '0;
      underflow              <= 1'b0;
    end else begin
      graycoded_read_pointer <= read_gray;
      if (flush) begin
        read_counter <= write_bin;
      end else if (pop_ack) begin
        read_counter <= read_counter + PTR_ONE;
      end
      if (pop & empty & ~flush) begin
        underflow <= 1'b1;
      end else if (clr_err) begin
        underflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_read_pointer_handler_param.sv
module tb_read_pointer_handler_param;

  localparam int ADDR_W    = 3;
  localparam int AEMPTY_TH = 2;
  localparam int W         = ADDR_W + 1;
  localparam int MASK      = (1 << W) - 1;
  localparam int DEPTH     = 1 << ADDR_W;

  logic              clk_rx = 1'b0;
  logic              nrst_rx;
  logic              pop;
  logic              flush;
  logic              clr_err;
  logic [ADDR_W:0]   synced_graycoded_write_pointer;
  logic              pop_ack;
  logic              empty;
  logic              almost_empty;
  logic [ADDR_W:0]   level;
  logic              underflow;
  logic [ADDR_W-1:0] read_pointer;
  logic [ADDR_W:0]   graycoded_read_pointer;

  int total = 0;
  int bad   = 0;

  // Reference state: how many entries have been consumed (mod 2^W), what the
  // published Gray pointer should be, and the sticky error.
  int m_rc;
  int m_g;
  int m_uf;
  int wb;

  always #5 clk_rx = ~clk_rx;

  read_pointer_handler_param #(.ADDR_W(ADDR_W), .AEMPTY_TH(AEMPTY_TH)) dut (
    .clk_rx                         (clk_rx),
    .nrst_rx                        (nrst_rx),
    .pop                            (pop),
    .flush                          (flush),
    .clr_err                        (clr_err),
    .synced_graycoded_write_pointer (synced_graycoded_write_pointer),
    .pop_ack                        (pop_ack),
    .empty                          (empty),
    .almost_empty                   (almost_empty),
    .level                          (level),
    .underflow                      (underflow),
    .read_pointer                   (read_pointer),
    .graycoded_read_pointer         (graycoded_read_pointer)
  );

  function automatic int gray(input int v);
    return (v ^ (v >> 1)) & MASK;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, check combinational and registered outputs
  // against the model, then advance the model across the edge.
  task automatic step(input bit r, input bit p, input bit f, input bit c, input int wbin);
    int lvl;
    bit emp;
    nrst_rx = r;
    pop     = p;
    flush   = f;
    clr_err = c;
    synced_graycoded_write_pointer = W'(gray(wbin & MASK));
    #1;
    lvl = ((wbin & MASK) - m_rc) & MASK;
    emp = (lvl == 0);
    chk("level",        32'(level),                  32'(lvl));
    chk("empty",        32'(empty),                  32'(emp));
    chk("almost_empty", 32'(almost_empty),           32'(lvl <= AEMPTY_TH));
    chk("pop_ack",      32'(pop_ack),                32'(p && !emp && !f));
    chk("read_pointer", 32'(read_pointer),           32'(m_rc % DEPTH));
    chk("gray_rptr",    32'(graycoded_read_pointer), 32'(m_g));
    chk("underflow",    32'(underflow),              32'(m_uf));
    @(posedge clk_rx);
    if (!r) begin
      m_rc = 0;
      m_g  = 0;
      m_uf = 0;
    end else begin
      m_g = gray(m_rc);
      if (f) m_rc = wbin & MASK;
      else if (p && !emp) m_rc = (m_rc + 1) & MASK;
      if (p && emp && !f) m_uf = 1;
      else if (c) m_uf = 0;
    end
    #1;
  endtask

  initial begin
    nrst_rx = 1'b0;
    pop     = 1'b0;
    flush   = 1'b0;
    clr_err = 1'b0;
    synced_graycoded_write_pointer = '0;
    m_rc = 0;
    m_g  = 0;
    m_uf = 0;
    repeat (2) @(posedge clk_rx);
    #1;

    // Reset state with write pointer 0.
    chk("rst_empty",  32'(empty),                  32'd1);
    chk("rst_aempty", 32'(almost_empty),           32'd1);
    chk("rst_level",  32'(level),                  32'd0);
    chk("rst_rptr",   32'(read_pointer),           32'd0);
    chk("rst_gray",   32'(graycoded_read_pointer), 32'd0);
    chk("rst_uf",     32'(underflow),              32'd0);
    chk("rst_ack",    32'(pop_ack),                32'd0);

    // Five entries visible, pop them all, then idle to see the Gray lag.
    for (int i = 0; i < 5; i++) step(1, 1, 0, 0, 5);
    step(1, 0, 0, 0, 5);
    chk("gray_after5", 32'(graycoded_read_pointer), 32'(4'b0111));

    // Wrap: jump to 14 via flush, then write pointer at 2 (level 4).
    step(1, 0, 1, 0, 14);
    for (int i = 0; i < 4; i++) step(1, 1, 0, 0, 2);
    step(1, 0, 0, 0, 2);
    chk("wrap_empty", 32'(empty), 32'd1);

    // Underflow: set, hold, clear, then set-wins-over-clear.
    step(1, 1, 0, 0, 2);
    step(1, 0, 0, 0, 2);
    step(1, 0, 0, 0, 2);
    step(1, 0, 0, 1, 2);
    step(1, 0, 0, 0, 2);
    step(1, 1, 0, 1, 2);
    step(1, 0, 0, 0, 2);
    chk("uf_set_wins", 32'(underflow), 32'd1);

    // Flush together with pop from counter 0, write pointer at 6.
    step(0, 0, 0, 0, 0);
    step(1, 1, 1, 0, 6);
    step(1, 0, 0, 0, 6);
    step(1, 0, 0, 0, 6);
    chk("flush_gray", 32'(graycoded_read_pointer), 32'(4'b0101));

    // Reset mid-stream with counter 3 and underflow set, pop held.
    step(0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 1, 0, 0, 3);
    step(1, 1, 0, 0, 3);
    step(0, 1, 0, 0, 3);
    chk("midrst_rptr", 32'(read_pointer),           32'd0);
    chk("midrst_uf",   32'(underflow),              32'd0);
    chk("midrst_gray", 32'(graycoded_read_pointer), 32'd0);

    // Randomised traffic with a monotonically advancing legal write pointer.
    wb = 0;
    for (int i = 0; i < 400; i++) begin
      int room;
      bit r, p, f, c;
      room = DEPTH - ((wb - m_rc) & MASK);
      if ($urandom_range(0, 2) == 0) wb = (wb + $urandom_range(0, room)) & MASK;
      r = ($urandom_range(0, 49) != 0);
      p = ($urandom_range(0, 9) < 6);
      f = ($urandom_range(0, 19) == 0);
      c = ($urandom_range(0, 9) == 0);
      step(r, p, f, c, wb);
      if (!r) wb = 0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
